// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the RV32 execute stage: ALU operation codes,
// operand source selects and the constant operand used for return addresses.
package ALU_defs;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9
  } t_enum_ALUSel;

  typedef enum logic [1:0] {
    RS1  = 2'd0,
    PC   = 2'd1,
    ZERO = 2'd2
  } t_enum_Op1Sel;

  typedef enum logic [1:0] {
    RS2  = 2'd0,
    IMM  = 2'd1,
    FOUR = 2'd2
  } t_enum_Op2Sel;

  localparam logic [31:0] OP2_FOUR = 32'd4;

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational RV32 integer ALU; shift amounts use the low five bits of op2.
module ALU
  import ALU_defs::*;
(
  input  logic [31:0]  op1,
  input  logic [31:0]  op2,
  input  t_enum_ALUSel aluSel,
  output logic [31:0]  aluOut
);

  // Operation decode
  always_comb begin
    aluOut = 32'd0;
    case (aluSel)
      ADD:     aluOut = op1 + op2;
      SUB:     aluOut = op1 - op2;
      SLL:     aluOut = op1 << op2[4:0];
      SLT:     aluOut = {31'd0, ($signed(op1) < $signed(op2))};
      SLTU:    aluOut = {31'd0, (op1 < op2)};
      XOR:     aluOut = op1 ^ op2;
      SRL:     aluOut = op1 >> op2[4:0];
      SRA:     aluOut = $signed(op1) >>> op2[4:0];
      OR:      aluOut = op1 | op2;
      AND:     aluOut = op1 & op2;
      default: aluOut = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// RV32 execute stage: operand select with bypass from the output register,
// one registered result slot toward writeback, flush and retired counter.
module alu_exec_stage
  import ALU_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [XLEN-1:0]  inPC,
  input  logic [XLEN-1:0]  inRs1Data,
  input  logic [XLEN-1:0]  inRs2Data,
  input  logic [4:0]       inRs1Addr,
  input  logic [4:0]       inRs2Addr,
  input  logic [XLEN-1:0]  inImm,
  input  t_enum_Op1Sel     inOp1Sel,
  input  t_enum_Op2Sel     inOp2Sel,
  input  t_enum_ALUSel     inAluSel,
  input  logic [4:0]       inRd,
  input  logic             inWbEn,
  output logic             outValid,
  input  logic             outReady,
  output logic [XLEN-1:0]  outResult,
  output logic [4:0]       outRd,
  output logic             outWbEn,
  output logic [XLEN-1:0]  execCount
);

  logic             out_valid_r;
  logic [XLEN-1:0]  out_result_r;
  logic [4:0]       out_rd_r;
  logic             out_wb_en_r;
  logic [XLEN-1:0]  exec_count_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             rs1_hit_s;
  logic             rs2_hit_s;
  logic [XLEN-1:0]  rs1_val_s;
  logic [XLEN-1:0]  rs2_val_s;
  logic [XLEN-1:0]  op1_s;
  logic [XLEN-1:0]  op2_s;
  logic [XLEN-1:0]  alu_out_s;

  // The slot frees up in the same cycle writeback consumes it; inValid never feeds inReady.
  assign in_ready_s = !flush && (!out_valid_r || outReady);
  assign accept_s   = inValid && in_ready_s;

  // x0 is never forwarded, and forwarding holds even while the slot is being drained.
  assign rs1_hit_s = out_valid_r && out_wb_en_r && (out_rd_r != 5'd0) && (out_rd_r == inRs1Addr);
  assign rs2_hit_s = out_valid_r && out_wb_en_r && (out_rd_r != 5'd0) && (out_rd_r == inRs2Addr);
  assign rs1_val_s = rs1_hit_s ? out_result_r : inRs1Data;
  assign rs2_val_s = rs2_hit_s ? out_result_r : inRs2Data;

  // Operand source selection
  always_comb begin
    op1_s = {XLEN{1'b0}};
    op2_s = {XLEN{1'b0}};
    case (inOp1Sel)
      RS1:     op1_s = rs1_val_s;
      PC:      op1_s = inPC;
      ZERO:    op1_s = {XLEN{1'b0}};
      default: op1_s = {XLEN{1'b0}};
    endcase
    case (inOp2Sel)
      RS2:     op2_s = rs2_val_s;
      IMM:     op2_s = inImm;
      FOUR:    op2_s = OP2_FOUR;
      default: op2_s = {XLEN{1'b0}};
    endcase
  end

  ALU u_alu (
    .op1    (op1_s),
    .op2    (op2_s),
    .aluSel (inAluSel),
    .aluOut (alu_out_s)
  );

  // Output slot and counter; flush drops only the valid bit, data fields hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {XLEN{1'b0}};
      out_rd_r     <= 5'd0;
      out_wb_en_r  <= 1'b0;
      exec_count_r <= {XLEN{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r  <= 1'b1;
      out_result_r <= alu_out_s;
      out_rd_r     <= inRd;
      out_wb_en_r  <= inWbEn;
      exec_count_r <= exec_count_r + {{(XLEN-1){1'b0}}, 1'b1};
    end else if (out_valid_r && outReady) begin
      out_valid_r <= 1'b0;
    end
  end

  assign inReady   = in_ready_s;
  assign outValid  = out_valid_r;
  assign outResult = out_result_r;
  assign outRd     = out_rd_r;
  assign outWbEn   = out_wb_en_r;
  assign execCount = exec_count_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_alu_exec_stage;
  import ALU_defs::*;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready;
  logic [31:0]  in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]   in_rs1_addr, in_rs2_addr, in_rd;
  t_enum_Op1Sel in_op1_sel;
  t_enum_Op2Sel in_op2_sel;
  t_enum_ALUSel in_alu_sel;
  logic         in_wb_en, out_valid, out_ready, out_wb_en;
  logic [31:0]  out_result, exec_count;
  logic [4:0]   out_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .inValid(in_valid), .inReady(in_ready),
    .inPC(in_pc), .inRs1Data(in_rs1_data), .inRs2Data(in_rs2_data),
    .inRs1Addr(in_rs1_addr), .inRs2Addr(in_rs2_addr), .inImm(in_imm),
    .inOp1Sel(in_op1_sel), .inOp2Sel(in_op2_sel), .inAluSel(in_alu_sel),
    .inRd(in_rd), .inWbEn(in_wb_en), .outValid(out_valid), .outReady(out_ready),
    .outResult(out_result), .outRd(out_rd), .outWbEn(out_wb_en), .execCount(exec_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input t_enum_Op1Sel s1, input t_enum_Op2Sel s2, input t_enum_ALUSel op,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rd, input logic wb);
    in_op1_sel = s1; in_op2_sel = s2; in_alu_sel = op;
    in_rs1_data = r1; in_rs2_data = r2; in_rs1_addr = a1; in_rs2_addr = a2;
    in_imm = imm; in_pc = pc; in_rd = rd; in_wb_en = wb; in_valid = 1'b1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(RS1, RS2, ADD, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    in_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", out_result); end
    checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", out_rd); end
    checks++; if (out_wb_en !== 1'b0) begin errors++; $display("FAIL reset_wben got=%b exp=0", out_wb_en); end
    checks++; if (exec_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", exec_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_inready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add_basic();
    out_ready = 1'b1;
    drive(RS1, RS2, ADD, 32'd5, 32'd7, 5'd1, 5'd2, 32'd0, 32'd0, 5'd3, 1'b1);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    checks++; if (out_result !== 32'd12) begin errors++; $display("FAIL add_result got=%h exp=%h", out_result, 32'd12); end
    checks++; if (out_rd !== 5'd3) begin errors++; $display("FAIL add_rd got=%0d exp=3", out_rd); end
    checks++; if (out_wb_en !== 1'b1) begin errors++; $display("FAIL add_wben got=%b exp=1", out_wb_en); end
    checks++; if (exec_count !== 32'd1) begin errors++; $display("FAIL add_count got=%0d exp=1", exec_count); end
    drain();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_bypass();
    out_ready = 1'b1;
    drive(RS1, IMM, ADD, 32'd0, 32'd0, 5'd0, 5'd0, 32'd10, 32'd0, 5'd1, 1'b1);
    step();
    drive(RS1, RS2, ADD, 32'd0, 32'd0, 5'd1, 5'd1, 32'd0, 32'd0, 5'd2, 1'b1);
    step();
    checks++; if (out_result !== 32'd20) begin errors++; $display("FAIL bypass_result got=%0d exp=20", out_result); end
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd2) begin errors++; $display("FAIL bypass_b2b got valid=%b rd=%0d exp valid=1 rd=2", out_valid, out_rd); end
    drive(RS1, IMM, ADD, 32'd0, 32'd0, 5'd0, 5'd0, 32'd10, 32'd0, 5'd0, 1'b1);
    step();
    checks++; if (out_result !== 32'd10) begin errors++; $display("FAIL bypass_x0_setup got=%0d exp=10", out_result); end
    drive(RS1, RS2, ADD, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd2, 1'b1);
    step();
    checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL bypass_x0 got=%0d exp=0", out_result); end
    drive(RS1, IMM, ADD, 32'd0, 32'd0, 5'd0, 5'd0, 32'd10, 32'd0, 5'd5, 1'b0);
    step();
    drive(RS1, RS2, ADD, 32'd1, 32'd1, 5'd5, 5'd5, 32'd0, 32'd0, 5'd6, 1'b1);
    step();
    checks++; if (out_result !== 32'd2) begin errors++; $display("FAIL bypass_nowb got=%0d exp=2", out_result); end
    checks++; if (exec_count !== 32'd7) begin errors++; $display("FAIL bypass_count got=%0d exp=7", exec_count); end
    drain();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(RS1, RS2, SUB, 32'd3, 32'd5, 5'd9, 5'd10, 32'd0, 32'd0, 5'd8, 1'b1);
    step();
    drive(RS1, RS2, ADD, 32'd1, 32'd1, 5'd1, 5'd2, 32'd0, 32'd0, 5'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_inready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_result !== 32'hFFFF_FFFE || out_rd !== 5'd8 || out_valid !== 1'b1)
        begin errors++; $display("FAIL stall_hold cyc=%0d got=%h rd=%0d v=%b exp=fffffffe rd=8 v=1", i, out_result, out_rd, out_valid); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_inready got=%b exp=1", in_ready); end
    step();
    checks++; if (out_result !== 32'd2 || out_rd !== 5'd4 || out_valid !== 1'b1)
      begin errors++; $display("FAIL stall_next got=%h rd=%0d v=%b exp=2 rd=4 v=1", out_result, out_rd, out_valid); end
    checks++; if (exec_count !== 32'd9) begin errors++; $display("FAIL stall_count got=%0d exp=9", exec_count); end
    drain();
  endtask

  task automatic test_op_selects();
    out_ready = 1'b1;
    drive(PC, FOUR, ADD, 32'h55, 32'h66, 5'd1, 5'd2, 32'h77, 32'h100, 5'd10, 1'b1);
    step();
    checks++; if (out_result !== 32'h104) begin errors++; $display("FAIL sel_pc_four got=%h exp=104", out_result); end
    drive(ZERO, IMM, ADD, 32'h55, 32'h66, 5'd1, 5'd2, 32'hFFFF_F800, 32'h100, 5'd11, 1'b1);
    step();
    checks++; if (out_result !== 32'hFFFF_F800) begin errors++; $display("FAIL sel_zero_imm got=%h exp=fffff800", out_result); end
    drive(RS1, IMM, SRA, 32'h8000_0000, 32'h1F, 5'd12, 5'd13, 32'd4, 32'h100, 5'd14, 1'b1);
    step();
    checks++; if (out_result !== 32'hF800_0000) begin errors++; $display("FAIL sel_sra got=%h exp=f8000000", out_result); end
    checks++; if (exec_count !== 32'd12) begin errors++; $display("FAIL sel_count got=%0d exp=12", exec_count); end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(RS1, RS2, ADD, 32'd1, 32'd2, 5'd1, 5'd2, 32'd0, 32'd0, 5'd5, 1'b1);
    step();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd3) begin errors++; $display("FAIL flush_setup got v=%b r=%h exp v=1 r=3", out_valid, out_result); end
    drive(RS1, RS2, ADD, 32'd4, 32'd4, 5'd1, 5'd2, 32'd0, 32'd0, 5'd6, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_inready got=%b exp=0", in_ready); end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (exec_count !== 32'd13) begin errors++; $display("FAIL flush_count got=%0d exp=13", exec_count); end
    checks++; if (out_result !== 32'd3 || out_rd !== 5'd5) begin errors++; $display("FAIL flush_data_hold got=%h rd=%0d exp=3 rd=5", out_result, out_rd); end
  endtask

  task automatic test_wrap_reset();
    out_ready = 1'b1;
    dut.exec_count_r = 32'hFFFF_FFFF;
    drive(RS1, IMM, ADD, 32'd1, 32'd0, 5'd1, 5'd2, 32'd1, 32'd0, 5'd7, 1'b1);
    step();
    checks++; if (exec_count !== 32'd0) begin errors++; $display("FAIL wrap_count got=%h exp=0", exec_count); end
    drive(RS1, IMM, ADD, 32'd1, 32'd0, 5'd1, 5'd2, 32'd1, 32'd0, 5'd7, 1'b1);
    step();
    checks++; if (exec_count !== 32'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL wrap_next got cnt=%0d v=%b exp cnt=1 v=1", exec_count, out_valid); end
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd !== 5'd0 || out_wb_en !== 1'b0)
      begin errors++; $display("FAIL rst_mid_outputs got v=%b r=%h rd=%0d wb=%b exp all 0", out_valid, out_result, out_rd, out_wb_en); end
    checks++; if (exec_count !== 32'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", exec_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_inready got=%b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_bypass();
    test_stall();
    test_op_selects();
    test_flush();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
